// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store per valid/ready handshake, LATENCY wait cycles, RV32 sizing.
// Optional macro DMEM_ERR_EN: misaligned and out-of-range accesses respond with rsp_err.
module dmem_responder #(
    parameter int DEPTH_WORDS = 2048,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, access;
    logic        a_we;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata;
    logic [AW-1:0] idx;
    logic        illegal, bad;
    logic [31:0] word, ld_val, wdata_pl;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  wmask;

    assign accept = req_valid && req_ready;
    assign access = (state_q == IDLE && accept && LATENCY == 0) ||
                    (state_q == BUSY && cnt_q == 4'd1);

    // With zero latency the access happens on the accept edge, so use the live request.
    always_comb begin
        a_we    = we_q;
        a_f3    = f3_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        if (state_q == IDLE) begin
            a_we    = req_we;
            a_f3    = req_funct3;
            a_addr  = req_addr;
            a_wdata = req_wdata;
        end
    end

    assign idx     = a_addr[AW+1:2];
    assign illegal = (a_f3 == 3'b011) || (a_f3[2:1] == 2'b11) || (a_we && a_f3[2]);
`ifdef DMEM_ERR_EN
    assign bad = illegal ||
                 (a_f3[1:0] == 2'b01 && a_addr[0]) ||
                 (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00) ||
                 (a_addr[31:AW+2] != '0);
`else
    logic unused_hi;
    assign unused_hi = ^a_addr[31:AW+2];
    assign bad = illegal;
`endif

    assign word = mem[idx];
    assign b    = word[{a_addr[1:0], 3'b000} +: 8];
    assign h    = a_addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (a_f3[1:0])
            2'b00: begin
                ld_val   = {{24{~a_f3[2] & b[7]}}, b};
                wmask    = 4'b0001 << a_addr[1:0];
                wdata_pl = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                ld_val   = {{16{~a_f3[2] & h[15]}}, h};
                wmask    = a_addr[1] ? 4'b1100 : 4'b0011;
                wdata_pl = {2{a_wdata[15:0]}};
            end
            default: begin
                ld_val   = word;
                wmask    = 4'b1111;
                wdata_pl = a_wdata;
            end
        endcase
        rdata_d = (a_we || bad) ? 32'd0 : ld_val;
    end

    // Array has no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && a_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata_pl[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d   = 4'(LATENCY);
                state_d = (LATENCY == 0) ? RESP : BUSY;
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (access) begin
                rdata_q <= rdata_d;
                err_q   <= bad;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has LATENCY=1, instance 1 has LATENCY=0.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_funct3[2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int pass_cnt = 0;
    int total    = 0;

    dmem_responder #(.DEPTH_WORDS(2048), .LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(2048), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // One full transaction; lat = edges after the accept edge until rsp_valid is seen.
    task automatic txn(input int d, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        int k;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata;
        k = 0;
        while (req_ready[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        total++;
        if (k >= 50 || lat >= 50) $display("FAIL txn_timeout: dut %0d addr %h waited %0d/%0d", d, addr, k, lat);
        else pass_cnt++;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk); #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;

    task automatic test_reset();
        #1;
        total++; if (rsp_valid[0] !== 1'b0) $display("FAIL rst_valid: got %b exp 0", rsp_valid[0]); else pass_cnt++;
        total++; if (req_ready[0] !== 1'b0) $display("FAIL rst_ready: got %b exp 0", req_ready[0]); else pass_cnt++;
        total++; if (rsp_rdata[0] !== 32'd0) $display("FAIL rst_rdata: got %h exp 0", rsp_rdata[0]); else pass_cnt++;
        total++; if (rsp_err[0] !== 1'b0) $display("FAIL rst_err: got %b exp 0", rsp_err[0]); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (req_ready[0] !== 1'b1) $display("FAIL rst_release_ready: got %b exp 1", req_ready[0]); else pass_cnt++;
    endtask

    task automatic test_word(input int d, input int exp_lat);
        txn(d, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lt);
        total++; if (lt !== exp_lat) $display("FAIL sw_latency d%0d: got %0d exp %0d", d, lt, exp_lat); else pass_cnt++;
        total++; if (er !== 1'b0 || rd !== 32'd0) $display("FAIL sw_rsp d%0d: got %h/%b exp 0/0", d, rd, er); else pass_cnt++;
        txn(d, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
        total++; if (lt !== exp_lat) $display("FAIL lw_latency d%0d: got %0d exp %0d", d, lt, exp_lat); else pass_cnt++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data d%0d: got %h exp deadbeef", d, rd); else pass_cnt++;
        total++; if (er !== 1'b0) $display("FAIL lw_err d%0d: got %b exp 0", d, er); else pass_cnt++;
    endtask

    task automatic test_byte();
        txn(0, 1'b1, 3'b010, 32'h10, 32'h0, rd, er, lt);
        txn(0, 1'b1, 3'b000, 32'h13, 32'h80, rd, er, lt);
        txn(0, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lt);
        total++; if (rd !== 32'hFFFFFF80) $display("FAIL lb: got %h exp ffffff80", rd); else pass_cnt++;
        txn(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h00000080) $display("FAIL lbu: got %h exp 00000080", rd); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h80000000) $display("FAIL lw_after_sb: got %h exp 80000000", rd); else pass_cnt++;
    endtask

    task automatic test_half();
        txn(0, 1'b1, 3'b010, 32'h20, 32'h0, rd, er, lt);
        txn(0, 1'b1, 3'b001, 32'h22, 32'hFFFF1234, rd, er, lt);
        txn(0, 1'b0, 3'b101, 32'h22, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h00001234) $display("FAIL lhu: got %h exp 00001234", rd); else pass_cnt++;
        txn(0, 1'b1, 3'b001, 32'h20, 32'h8001, rd, er, lt);
        txn(0, 1'b0, 3'b001, 32'h20, 32'h0, rd, er, lt);
        total++; if (rd !== 32'hFFFF8001) $display("FAIL lh: got %h exp ffff8001", rd); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h12348001) $display("FAIL lw_after_sh: got %h exp 12348001", rd); else pass_cnt++;
    endtask

    task automatic test_illegal();
        txn(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lt);
        total++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL ill_f3_load: got %h/%b exp 0/1", rd, er); else pass_cnt++;
        txn(0, 1'b1, 3'b100, 32'h10, 32'hFF, rd, er, lt);
        total++; if (er !== 1'b1) $display("FAIL ill_store_bu: got %b exp 1", er); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h80000000) $display("FAIL ill_no_write: got %h exp 80000000", rd); else pass_cnt++;
    endtask

    task automatic test_range();
        txn(0, 1'b1, 3'b010, 32'h0, 32'h01020304, rd, er, lt);
        txn(0, 1'b1, 3'b010, 32'h2000, 32'hA5A5A5A5, rd, er, lt);
`ifdef DMEM_ERR_EN
        total++; if (er !== 1'b1) $display("FAIL oor_err: got %b exp 1", er); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h0, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h01020304) $display("FAIL oor_no_write: got %h exp 01020304", rd); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h11, 32'h0, rd, er, lt);
        total++; if (er !== 1'b1 || rd !== 32'd0) $display("FAIL misalign: got %h/%b exp 0/1", rd, er); else pass_cnt++;
`else
        total++; if (er !== 1'b0) $display("FAIL wrap_err: got %b exp 0", er); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h0, 32'h0, rd, er, lt);
        total++; if (rd !== 32'hA5A5A5A5) $display("FAIL wrap_write: got %h exp a5a5a5a5", rd); else pass_cnt++;
`endif
    endtask

    task automatic test_backpressure();
        int k;
        txn(0, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, rd, er, lt);
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'b010; req_addr[0] = 32'h30;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        k = 0;
        while (rsp_valid[0] !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
        total++; if (k >= 50) $display("FAIL bp_timeout: waited %0d", k); else pass_cnt++;
        // Competing store while the response is stalled must be ignored.
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wdata[0] = 32'hFFFFFFFF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid[0] !== 1'b1) $display("FAIL bp_valid c%0d: got %b exp 1", c, rsp_valid[0]); else pass_cnt++;
            total++; if (rsp_rdata[0] !== 32'h0BADF00D) $display("FAIL bp_rdata c%0d: got %h exp 0badf00d", c, rsp_rdata[0]); else pass_cnt++;
            total++; if (req_ready[0] !== 1'b0) $display("FAIL bp_ready c%0d: got %b exp 0", c, req_ready[0]); else pass_cnt++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        total++; if (rsp_valid[0] !== 1'b0) $display("FAIL bp_release_valid: got %b exp 0", rsp_valid[0]); else pass_cnt++;
        total++; if (req_ready[0] !== 1'b1) $display("FAIL bp_release_ready: got %b exp 1", req_ready[0]); else pass_cnt++;
        txn(0, 1'b0, 3'b010, 32'h30, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h0BADF00D) $display("FAIL bp_ignored_store: got %h exp 0badf00d", rd); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        txn(0, 1'b1, 3'b010, 32'h40, 32'h11223344, rd, er, lt);
        txn(0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lt);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'b010;
        req_addr[0] = 32'h40; req_wdata[0] = 32'h55;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (rsp_valid[0] !== 1'b0) $display("FAIL mid_rst_valid: got %b exp 0", rsp_valid[0]); else pass_cnt++;
        total++; if (req_ready[0] !== 1'b0) $display("FAIL mid_rst_ready: got %b exp 0", req_ready[0]); else pass_cnt++;
        total++; if (rsp_rdata[0] !== 32'd0) $display("FAIL mid_rst_rdata: got %h exp 0", rsp_rdata[0]); else pass_cnt++;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        txn(0, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lt);
        total++; if (rd !== 32'h11223344) $display("FAIL mid_rst_store_dropped: got %h exp 11223344", rd); else pass_cnt++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'b010;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
        end
        test_reset();
        test_word(0, 1);
        test_byte();
        test_half();
        test_illegal();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_word(1, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
